// File: rtl/float2int_conv.sv
// rtl/float2int_conv.sv - sequential float-to-int32 converter with saturation
//
// Converts a {signe, exponent, mantisse} float operand into a 32-bit signed
// integer. The magnitude is aligned one bit position per clock, so latency
// depends on the exponent: done rises k+2 edges after the accepting edge,
// where k is the shift count (0 for zero, saturation and exact cases).
//
// Optional feature macro: FLOAT2INT_ROUND_EN
//   undefined : truncation toward zero
//   defined   : round-to-nearest-even using guard/sticky bits collected
//               during right shifts
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   conversion request, sampled only while idle
//   float_in  in   operand {signe, exponent[Ne], mantisse[Nm]}
//   busy      out  conversion in progress
//   done      out  one-cycle pulse, int_out/overflow valid
//   int_out   out  signed result, held until the next done
//   overflow  out  saturation flag, held with int_out

module float2int_conv #(
   parameter int Nm = 23,
   parameter int Ne = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic [Ne+Nm:0] float_in,
   output logic           busy,
   output logic           done,
   output logic [31:0]    int_out,
   output logic           overflow
);

   localparam int B    = 2**(Ne-1) - 1;
   // Magnitude register must hold both the full significand and a 32-bit result.
   localparam int MW   = (Nm + 1 > 32) ? Nm + 1 : 32;
   localparam int KMAX = (Nm + 1 > 30) ? Nm + 1 : 30;
   localparam int KW   = $clog2(KMAX + 1);
   // Unbiased exponent width: two extra bits cover the sign and the bias range.
   localparam int EW   = Ne + 2;

   localparam logic signed [EW-1:0] B_S   = EW'(B);
   localparam logic signed [EW-1:0] NM_S  = EW'(Nm);
   localparam logic signed [EW-1:0] E31_S = EW'(31);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_FINISH
   } state_t;

   state_t state_q, state_nxt;

   // Operand fields
   logic                 f_sign;
   logic [Ne-1:0]        f_exp;
   logic [Nm-1:0]        f_mant;
   logic signed [EW-1:0] f_e;

   assign f_sign = float_in[Ne+Nm];
   assign f_exp  = float_in[Ne+Nm-1:Nm];
   assign f_mant = float_in[Nm-1:0];
   assign f_e    = $signed({2'b00, f_exp}) - B_S;

   // Classification results, consumed on the accepting edge
   logic [MW-1:0] cls_mag;
   logic [KW-1:0] cls_k;
   logic          cls_left;
   logic          cls_sat;

   always_comb begin
      cls_mag  = '0;
      cls_k    = '0;
      cls_left = 1'b0;
      cls_sat  = 1'b0;
      if (f_exp == '0) begin
         // zero and denormals flush to zero
         cls_mag = '0;
      end else if (f_e > E31_S) begin
         cls_sat = 1'b1;
      end else if (f_e == E31_S) begin
         // only -2**31 itself is representable at this exponent
         if (f_sign && (f_mant == '0)) begin
            cls_mag[31] = 1'b1;
         end else begin
            cls_sat = 1'b1;
         end
      end else if (!f_e[EW-1]) begin
         cls_mag = MW'({1'b1, f_mant});
         if (f_e >= NM_S) begin
            cls_left = 1'b1;
            cls_k    = KW'(f_e - NM_S);
         end else begin
            cls_k    = KW'(NM_S - f_e);
         end
`ifdef FLOAT2INT_ROUND_EN
      end else if (&f_e) begin
         // e = -1: value in [0.5, 1), shift everything out so guard/sticky
         // decide whether it rounds up to 1
         cls_mag = MW'({1'b1, f_mant});
         cls_k   = KW'(Nm + 1);
`endif
      end
   end

   // Datapath state
   logic          sign_q;
   logic          sat_q;
   logic          left_q;
   logic [MW-1:0] mag_q;
   logic [KW-1:0] k_q;
`ifdef FLOAT2INT_ROUND_EN
   logic          guard_q;
   logic          sticky_q;
`endif

   // Control strobes
   logic load;
   logic shift_en;
   logic finish_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      load      = 1'b0;
      shift_en  = 1'b0;
      finish_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = (cls_k == '0) ? S_FINISH : S_SHIFT;
            end
         end
         S_SHIFT: begin
            shift_en = 1'b1;
            if (k_q == KW'(1)) begin
               state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            finish_en = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy = (state_q != S_IDLE);

   // Final magnitude with one spare bit so a rounding carry out of bit 31
   // is visible to the saturation check.
   logic [32:0] mag_r;
   logic        res_sat;
   logic [31:0] res_val;

`ifdef FLOAT2INT_ROUND_EN
   logic rnd_inc;
   assign rnd_inc = guard_q & (sticky_q | mag_q[0]);
   assign mag_r   = {1'b0, mag_q[31:0]} + 33'(rnd_inc);
`else
   assign mag_r   = {1'b0, mag_q[31:0]};
`endif

   always_comb begin
      res_sat = sat_q;
      if (sign_q) begin
         if (mag_r > 33'h0_8000_0000) begin
            res_sat = 1'b1;
         end
      end else begin
         if (mag_r > 33'h0_7FFF_FFFF) begin
            res_sat = 1'b1;
         end
      end
      if (res_sat) begin
         res_val = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         res_val = sign_q ? (32'd0 - mag_r[31:0]) : mag_r[31:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sign_q   <= 1'b0;
         sat_q    <= 1'b0;
         left_q   <= 1'b0;
         mag_q    <= '0;
         k_q      <= '0;
`ifdef FLOAT2INT_ROUND_EN
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
`endif
         done     <= 1'b0;
         int_out  <= '0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            sign_q   <= f_sign;
            sat_q    <= cls_sat;
            left_q   <= cls_left;
            mag_q    <= cls_mag;
            k_q      <= cls_k;
`ifdef FLOAT2INT_ROUND_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
         end else if (shift_en) begin
            k_q <= k_q - KW'(1);
            if (left_q) begin
               mag_q <= {mag_q[MW-2:0], 1'b0};
            end else begin
               mag_q <= {1'b0, mag_q[MW-1:1]};
`ifdef FLOAT2INT_ROUND_EN
               // previous guard bit is now an earlier shifted-out bit
               guard_q  <= mag_q[0];
               sticky_q <= sticky_q | guard_q;
`endif
            end
         end
         if (finish_en) begin
            int_out  <= res_val;
            overflow <= res_sat;
            done     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_float2int_conv.sv
// tb/tb_float2int_conv.sv - self-checking bench for float2int_conv

module tb_float2int_conv;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] float_in;
   logic        busy;
   logic        done;
   logic [31:0] int_out;
   logic        overflow;

   int total;
   int bad;

   float2int_conv #(.Nm(23), .Ne(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .float_in (float_in),
      .busy     (busy),
      .done     (done),
      .int_out  (int_out),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] f;
      logic [31:0] exp_int;
      logic        exp_ovf;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a falling edge; returns at the falling edge where done is seen.
   task automatic run_conv(input logic [31:0] f, output logic [31:0] r, output logic o,
                           output int lat, output int bcnt);
      float_in = f;
      start    = 1'b1;
      lat      = -1;
      bcnt     = 0;
      @(posedge clk);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = n + 1;
            break;
         end
         if (busy) bcnt++;
         @(posedge clk);
      end
      r = int_out;
      o = overflow;
      if (lat < 0) begin
         total++;
         bad++;
         $display("FAIL timeout: no done for operand %h", f);
      end
   endtask

   // Reference model: evaluates the float value with real arithmetic.
   task automatic model(input logic [31:0] f, output logic [31:0] r, output logic o, output int lat);
      logic  s;
      int    ex;
      int    m;
      int    e;
      int    lo;
      real   v;
      longint q;
      s  = f[31];
      ex = int'(f[30:23]);
      m  = int'(f[22:0]);
      e  = ex - 127;
`ifdef FLOAT2INT_ROUND_EN
      lo = -1;
`else
      lo = 0;
`endif
      r = 32'd0;
      o = 1'b0;
      lat = 2;
      if (ex == 0 || e < lo) begin
         r = 32'd0;
      end else if (e > 31 || (e == 31 && !(s && m == 0))) begin
         r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
         o = 1'b1;
      end else if (e == 31) begin
         r = 32'h8000_0000;
      end else begin
         v = 8388608.0 + real'(m);
         if (e >= 23) begin
            for (int i = 0; i < e - 23; i++) v = v * 2.0;
            lat = e - 23 + 2;
         end else begin
            for (int i = 0; i < 23 - e; i++) v = v / 2.0;
            lat = 23 - e + 2;
         end
         q = longint'($rtoi(v));
`ifdef FLOAT2INT_ROUND_EN
         if ((v - real'(q) > 0.5) || ((v - real'(q) == 0.5) && q[0])) q = q + 1;
`endif
         if (!s && q > 64'sd2147483647) begin
            r = 32'h7FFF_FFFF;
            o = 1'b1;
         end else begin
            r = s ? 32'(-q) : 32'(q);
         end
      end
   endtask

   initial begin
      logic [31:0] r;
      logic        o;
      int          lat;
      int          bcnt;
      logic [31:0] er;
      logic        eo;
      int          elat;
      int          dcnt;
      logic [31:0] dval;
      int          dn[$];
      logic [31:0] dv[$];
      logic [31:0] f;

      total = 0;
      bad   = 0;

      vecs.push_back('{32'h4049_0FDB, 32'd3,          1'b0, 24});
      vecs.push_back('{32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 19});
      vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 2});
      vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 1'b0, 2});
      vecs.push_back('{32'h7F7F_FFFF, 32'h7FFF_FFFF, 1'b1, 2});
      vecs.push_back('{32'h0000_0000, 32'd0,          1'b0, 2});
      vecs.push_back('{32'h8000_0000, 32'd0,          1'b0, 2});
      vecs.push_back('{32'h4020_0000, 32'd2,          1'b0, 24});
      vecs.push_back('{32'h4120_0000, 32'd10,         1'b0, 22});
      vecs.push_back('{32'h4B00_0000, 32'h0080_0000, 1'b0, 2});
      vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 9});
      vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 1'b1, 2});
      vecs.push_back('{32'hCF00_0001, 32'h8000_0000, 1'b1, 2});
      vecs.push_back('{32'h0040_0000, 32'd0,          1'b0, 2});
`ifdef FLOAT2INT_ROUND_EN
      vecs.push_back('{32'h3FC0_0000, 32'd2,          1'b0, 25});
      vecs.push_back('{32'h3F00_0000, 32'd0,          1'b0, 26});
      vecs.push_back('{32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0, 25});
`else
      vecs.push_back('{32'h3FC0_0000, 32'd1,          1'b0, 25});
      vecs.push_back('{32'h3F00_0000, 32'd0,          1'b0, 2});
      vecs.push_back('{32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 25});
`endif

      // Reset state
      reset_n  = 1'b0;
      start    = 1'b0;
      float_in = 32'd0;
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_int_out", int_out, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Directed table
      foreach (vecs[i]) begin
         run_conv(vecs[i].f, r, o, lat, bcnt);
         check($sformatf("vec%0d_int", i), r, vecs[i].exp_int);
         check($sformatf("vec%0d_ovf", i), {31'd0, o}, {31'd0, vecs[i].exp_ovf});
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(vecs[i].exp_lat - 1));
      end

      // Outputs hold while idle
      repeat (5) @(negedge clk);
      check("hold_int_out", int_out, vecs[vecs.size()-1].exp_int);
      check("hold_done", {31'd0, done}, 32'd0);

      // Second start mid-conversion is ignored
      float_in = 32'h4120_0000;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      float_in = 32'h3F80_0000;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dcnt = 0;
      dval = 32'd0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) begin
            dcnt++;
            dval = int_out;
         end
      end
      check("ignore_done_count", 32'(dcnt), 32'd1);
      check("ignore_result", dval, 32'd10);

      // Start held high: back-to-back conversions
      float_in = 32'h4120_0000;
      start    = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (done) begin
            dn.push_back(n);
            dv.push_back(int_out);
            float_in = 32'hC2F6_0000;
         end
         @(posedge clk);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      check("b2b_count", 32'(dn.size()), 32'd4);
      if (dn.size() >= 2) begin
         check("b2b_first_edge", 32'(dn[0]), 32'd21);
         check("b2b_first_val", dv[0], 32'd10);
         check("b2b_second_edge", 32'(dn[1]), 32'd40);
         check("b2b_second_val", dv[1], 32'hFFFF_FF85);
      end

      // Reset during SHIFT
      float_in = 32'h4049_0FDB;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_int_out", int_out, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      check("rst_done_hold", {31'd0, done}, 32'd0);
      reset_n = 1'b1;
      run_conv(32'h4120_0000, r, o, lat, bcnt);
      check("post_rst_int", r, 32'd10);
      check("post_rst_lat", 32'(lat), 32'd22);

      // Randomized against the reference model
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            f = $urandom;
         end else begin
            f[31]    = 1'($urandom_range(0, 1));
            f[30:23] = 8'(124 + $urandom_range(0, 36));
            f[22:0]  = 23'($urandom);
         end
         model(f, er, eo, elat);
         run_conv(f, r, o, lat, bcnt);
         check($sformatf("rnd%0d_int_%h", i, f), r, er);
         check($sformatf("rnd%0d_ovf_%h", i, f), {31'd0, o}, {31'd0, eo});
         check($sformatf("rnd%0d_lat_%h", i, f), 32'(lat), 32'(elat));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/float2int_conv.md
FLOAT2INT_CONV -- requirements
Module: float2int_conv

Interface
REQ-001 SHALL have parameter Nm, default 23: mantissa field width of the coprocessor float format.
REQ-002 SHALL have parameter Ne, default 8: exponent field width; bias B = 2**(Ne-1)-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a conversion; sampled only in IDLE.
REQ-006 float_in  input  1+Ne+Nm  operand as {signe, exponent, mantisse}; sampled on the accepting edge only.
REQ-007 busy  output  1  high while a conversion is in progress (state != IDLE).
REQ-008 done  output  1  one-cycle pulse when int_out is valid.
REQ-009 int_out  output  32  signed two's-complement result; held until the next done.
REQ-010 overflow  output  1  saturation flag; valid with done, held with int_out.

Function
REQ-011 SHALL convert float_in to a 32-bit signed integer, truncating toward zero (default build).
REQ-012 SHALL implement states IDLE, SHIFT and FINISH.
- IDLE: start=1 -> capture operand, classify, load shift register and counter k.
- If special or k=0 -> FINISH, else -> SHIFT.
REQ-013 SHALL use e = exponent - B for classification.
- exponent=0 (zero/denormal, flushed) -> 0.
- e<0 -> 0.
- e>31, or e=31 except the exact -2**31 case -> saturate.
- e=31, signe=1, mantisse=0 -> 0x80000000, overflow=0.
- Specials SHALL take k=0.
REQ-014 SHALL, for 0<=e<=30, load magnitude {1,mantisse} and set k=|e-Nm|, shifting left when e>=Nm and right otherwise.
REQ-015 SHALL, in SHIFT, move one bit position per clock and decrement k; after the last shift -> FINISH.
REQ-016 SHALL, in FINISH, negate the magnitude if signe=1, register int_out and overflow, pulse done, and return to IDLE.
REQ-017 SHALL assert done exactly k+2 rising edges after the edge accepting start; busy SHALL be high for the k+1 cycles between.
REQ-018 SHALL saturate to 0x7FFFFFFF (signe=0) or 0x80000000 (signe=1) with overflow=1.
REQ-019 SHALL ignore start while busy=1.
- A start coincident with done (state IDLE) SHALL be accepted.
REQ-020 SHALL not change int_out or overflow except on the FINISH edge or reset.

Reset
REQ-021 reset_n=0 SHALL immediately force: state IDLE, busy=0, done=0, int_out=0, overflow=0, counter=0.
- An in-flight conversion SHALL be discarded without a done pulse.
REQ-022 SHALL accept a new start on the first edge after reset_n deasserts.

Configuration
REQ-023 Macro FLOAT2INT_ROUND_EN SHALL select the rounding mode:
- Defined: round-to-nearest-even using guard (last bit shifted out) and sticky (OR of earlier bits shifted out), tracked during right shifts.
- Defined: e=-1 SHALL take the shift path with k=Nm+1; e<-1 -> 0.
- Defined: increment SHALL be applied in FINISH before negation; magnitude >2**31-1 (positive) SHALL saturate with overflow=1.
- Undefined: truncation; no guard/sticky logic synthesized.

Verification
REQ-024 float_in=0x40490FDB (3.14159), start -> done 24 edges later, int_out=3, overflow=0.
REQ-025 float_in=0xC2F60000 (-123.0) -> done after 19 edges, int_out=0xFFFFFF85, overflow=0.
REQ-026 Boundary cases:
- 0x4F000000 -> 0x7FFFFFFF, overflow=1.
- 0xCF000000 -> 0x80000000, overflow=0.
- 0x7F7FFFFF -> 0x7FFFFFFF, overflow=1.
- 0x00000000 and 0x80000000 -> 0.
- All of the above: done 2 edges after start.
REQ-027 Rounding cases:
- 0x3FC00000 (1.5) -> 1 default, 2 with FLOAT2INT_ROUND_EN.
- 0x3F000000 (0.5) -> 0 both builds.
- 0x40200000 (2.5) -> 2 both builds.
- 0xBFC00000 (-1.5) -> -1 default, -2 rounded.
REQ-028 Handshake cases:
- Second start pulsed mid-conversion -> ignored, single done, first result.
- start held high -> back-to-back conversions, one accepted on each done cycle.
REQ-029 Reset case: reset_n low for 1 cycle during SHIFT -> all outputs 0 immediately, no done; next start converts 0x41200000 -> 10.
